bram_rd_arbiter: RTL and testbench

Two-requester read-port arbiter for the body-state BRAM (`ram_2_port`, 80-bit words, 15-bit address) in the N-body simulator. It shares the single BRAM read port between requester 0 (the force/integration engine) and requester 1 (the host/readback path that dumps body state after `done`). Arbitration is round-robin with one grant per cycle. Each read returns to the requester that issued it, in issue order, after a fixed latency.

---
 rtl/bram_rd_arbiter.sv | 127 ++++++++++++
 tb/tb_bram_rd_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_arbiter.sv
// bram_rd_arbiter
//   Shares the single read port of the body-state BRAM between two requesters
//   (0: force/integration engine, 1: host readback). The grant is round-robin,
//   with one grant per cycle. A tag pipeline returns each read to the
//   requester that issued it, in issue order, after a fixed latency.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   reqN_valid/addr/ready      read request handshake (N = 0, 1)
//   rspN_valid/data            read response for requester N. Valid is a
//                              one-cycle pulse, and data holds its value
//                              between responses.
//   bram_rdaddress             registered read address to the RAM
//   bram_q                     RAM read data
//   busy                       at least one read in flight (registered)
module bram_rd_arbiter #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 80,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] bram_rdaddress,
    input  logic [DATA_W-1:0] bram_q,
    output logic              busy
);

    // One stage for the address register, plus RD_LAT stages for the RAM itself.
    localparam int unsigned Depth = RD_LAT + 1;

    logic              last_q, last_d;
    logic [ADDR_W-1:0] rdaddr_q;
    logic [Depth-1:0]  tag_vld_q, tag_vld_d;
    logic [Depth-1:0]  tag_id_q, tag_id_d;
    logic              rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;
    logic              busy_q;

    logic gnt0, gnt1, accept;
    logic ret_vld, ret_id;

    // Round-robin grant. last_q holds the requester granted most recently.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign accept = gnt0 | gnt1;

    always_comb begin
        last_d    = last_q;
        tag_vld_d = '0;
        tag_id_d  = '0;
        if (accept) begin
            last_d = gnt1;
        end
        tag_vld_d[0] = accept;
        tag_id_d[0]  = gnt1;
        for (int unsigned i = 1; i < Depth; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    // The tag leaving the last stage is the one whose RAM data is on bram_q now.
    assign ret_vld = tag_vld_q[Depth-1];
    assign ret_id  = tag_id_q[Depth-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= 1'b1;
            rdaddr_q     <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            last_q       <= last_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp0_valid_q <= ret_vld && !ret_id;
            rsp1_valid_q <= ret_vld && ret_id;
            busy_q       <= |tag_vld_d;
            if (accept) begin
                rdaddr_q <= gnt1 ? req1_addr : req0_addr;
            end
            if (ret_vld && !ret_id) begin
                rsp0_data_q <= bram_q;
            end
            if (ret_vld && ret_id) begin
                rsp1_data_q <= bram_q;
            end
        end
    end

    assign req0_ready     = gnt0;
    assign req1_ready     = gnt1;
    assign rsp0_valid     = rsp0_valid_q;
    assign rsp1_valid     = rsp1_valid_q;
    assign rsp0_data      = rsp0_data_q;
    assign rsp1_data      = rsp1_data_q;
    assign bram_rdaddress = rdaddr_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Testbench for bram_rd_arbiter. Two instances share the same stimulus:
// index 0 uses RD_LAT=1 with an unregistered-output RAM model, and index 1
// uses RD_LAT=2 with a registered-output RAM model. A cycle-based scoreboard
// predicts grants, responses, data, busy and the read address. Literal checks
// pin the scoreboard itself.
module tb_bram_rd_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [14:0] req0_addr, req1_addr;

    logic        req0_ready_w     [2];
    logic        req1_ready_w     [2];
    logic        rsp0_valid_w     [2];
    logic        rsp1_valid_w     [2];
    logic [79:0] rsp0_data_w      [2];
    logic [79:0] rsp1_data_w      [2];
    logic [14:0] bram_rdaddress_w [2];
    logic [79:0] bram_q_w         [2];
    logic        busy_w           [2];

    logic [79:0] mem [0:32767];
    logic [14:0] ram_a [2];
    logic [79:0] ram_r;

    int checks = 0;
    int errors = 0;

    bram_rd_arbiter #(.ADDR_W(15), .DATA_W(80), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready_w[0]),
        .rsp0_valid(rsp0_valid_w[0]), .rsp0_data(rsp0_data_w[0]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready_w[0]),
        .rsp1_valid(rsp1_valid_w[0]), .rsp1_data(rsp1_data_w[0]),
        .bram_rdaddress(bram_rdaddress_w[0]), .bram_q(bram_q_w[0]), .busy(busy_w[0])
    );

    bram_rd_arbiter #(.ADDR_W(15), .DATA_W(80), .RD_LAT(2)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready_w[1]),
        .rsp0_valid(rsp0_valid_w[1]), .rsp0_data(rsp0_data_w[1]),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready_w[1]),
        .rsp1_valid(rsp1_valid_w[1]), .rsp1_data(rsp1_data_w[1]),
        .bram_rdaddress(bram_rdaddress_w[1]), .bram_q(bram_q_w[1]), .busy(busy_w[1])
    );

    // RAM models: the address is registered inside the RAM, and the output is
    // optionally registered.
    always @(posedge clk) begin
        ram_a[0] <= bram_rdaddress_w[0];
        ram_a[1] <= bram_rdaddress_w[1];
        ram_r    <= mem[ram_a[1]];
    end
    assign bram_q_w[0] = mem[ram_a[0]];
    assign bram_q_w[1] = ram_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state. Slots are indexed by the cycle in which a response is due.
    logic        sv   [2][8];
    logic        sid  [2][8];
    logic [79:0] sdat [2][8];
    int          outst [2];
    logic [79:0] ed [2][2];
    logic [14:0] ea [2];
    int          rcnt [2][2];
    logic        m_last, m_acc, m_gid;
    int          cyc;

    int          gid_log [$];
    logic [14:0] ra_log  [$];
    logic [14:0] sa0 [8];
    logic [14:0] sa1 [8];
    int          sn0, sn1, s_ticks;

    function automatic logic [79:0] word(input logic [14:0] a);
        return {5{1'b0, a}};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
            outst[k] = 0;
            ed[k][0] = '0;
            ed[k][1] = '0;
            ea[k]    = '0;
        end
        m_last = 1'b1;
    endtask

    task automatic model_check();
        logic g0, g1;
        int   s;
        s = cyc % 8;
        for (int k = 0; k < 2; k++) begin
            logic ev, eid;
            ev  = sv[k][s];
            eid = sid[k][s];
            if (ev) begin
                ed[k][eid] = sdat[k][s];
                outst[k]--;
                sv[k][s] = 1'b0;
            end
            if (rsp0_valid_w[k]) rcnt[k][0]++;
            if (rsp1_valid_w[k]) rcnt[k][1]++;
            chk($sformatf("rsp0_valid lat%0d", k + 1), 80'(rsp0_valid_w[k]), 80'(ev && !eid));
            chk($sformatf("rsp1_valid lat%0d", k + 1), 80'(rsp1_valid_w[k]), 80'(ev && eid));
            chk($sformatf("rsp0_data lat%0d", k + 1), rsp0_data_w[k], ed[k][0]);
            chk($sformatf("rsp1_data lat%0d", k + 1), rsp1_data_w[k], ed[k][1]);
            chk($sformatf("busy lat%0d", k + 1), 80'(busy_w[k]), 80'(outst[k] > 0));
            chk($sformatf("bram_rdaddress lat%0d", k + 1), 80'(bram_rdaddress_w[k]), 80'(ea[k]));
        end
        // Only one valid: grant it. Both valid: grant the one not granted last.
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                if (m_last) g0 = 1'b1;
                else        g1 = 1'b1;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req0_ready lat%0d", k + 1), 80'(req0_ready_w[k]), 80'(g0));
            chk($sformatf("req1_ready lat%0d", k + 1), 80'(req1_ready_w[k]), 80'(g1));
        end
        m_acc = g0 | g1;
        m_gid = g1;
        if (reset) begin
            model_reset();
        end else if (m_acc) begin
            for (int k = 0; k < 2; k++) begin
                int due;
                due = (cyc + k + 3) % 8;  // accept cycle + RD_LAT + 2
                sv[k][due]   = 1'b1;
                sid[k][due]  = g1;
                sdat[k][due] = mem[g1 ? req1_addr : req0_addr];
                outst[k]++;
                ea[k] = g1 ? req1_addr : req0_addr;
            end
            m_last = g1;
        end
    endtask

    // Inputs change 1 time unit after a posedge, and outputs are checked at the negedge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    task automatic stream();
        int i0, i1;
        i0 = 0;
        i1 = 0;
        s_ticks = 0;
        gid_log.delete();
        ra_log.delete();
        while ((i0 < sn0 || i1 < sn1) && s_ticks < 64) begin
            req0_valid = (i0 < sn0);
            req0_addr  = (i0 < sn0) ? sa0[i0] : 15'd0;
            req1_valid = (i1 < sn1);
            req1_addr  = (i1 < sn1) ? sa1[i1] : 15'd0;
            tick();
            s_ticks++;
            if (m_acc) begin
                gid_log.push_back(int'(m_gid));
                ra_log.push_back(bram_rdaddress_w[0]);
                if (m_gid) i1++;
                else       i0++;
            end
        end
        if (i0 < sn0 || i1 < sn1) chk("stream_timeout", 80'(s_ticks), 80'(0));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            rcnt[k][0] = 0;
            rcnt[k][1] = 0;
        end
    endtask

    initial begin
        int          exp_gid [6];
        logic [14:0] exp_ra  [6];
        for (int i = 0; i < 32768; i++) mem[i] = word(15'(i));
        mem[3]        = 80'h0000_1111_2222_3333_4444;
        mem[15'h7FFF] = '1;
        model_reset();
        clear_counts();
        cyc        = 0;
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        @(posedge clk);
        #1;
        tick();
        reset = 1'b0;

        // Single read of word 3 by requester 0.
        clear_counts();
        req0_valid = 1'b1;
        req0_addr  = 15'd3;
        tick();
        req0_valid = 1'b0;
        drain();
        for (int k = 0; k < 2; k++) begin
            chk("s1_rsp0_data", rsp0_data_w[k], 80'h0000_1111_2222_3333_4444);
            chk("s1_rsp0_count", 80'(rcnt[k][0]), 80'd1);
            chk("s1_rsp1_count", 80'(rcnt[k][1]), 80'd0);
        end

        // Contention from reset: the two requesters alternate, starting with requester 0.
        reset      = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 15'd0;
        req1_valid = 1'b1;
        req1_addr  = 15'h190;
        tick();
        tick();
        reset = 1'b0;
        clear_counts();
        sa0 = '{15'd0, 15'd1, 15'd2, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};
        sa1 = '{15'h190, 15'h191, 15'h192, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};
        sn0 = 3;
        sn1 = 3;
        stream();
        drain();
        exp_gid = '{0, 1, 0, 1, 0, 1};
        exp_ra  = '{15'h0, 15'h190, 15'h1, 15'h191, 15'h2, 15'h192};
        chk("s2_accepts", 80'(gid_log.size()), 80'd6);
        for (int i = 0; i < 6 && i < gid_log.size(); i++) begin
            chk($sformatf("s2_grant%0d", i), 80'(gid_log[i]), 80'(exp_gid[i]));
            chk($sformatf("s2_rdaddr%0d", i), 80'(ra_log[i]), 80'(exp_ra[i]));
        end
        for (int k = 0; k < 2; k++) begin
            chk("s2_rsp0_data", rsp0_data_w[k], 80'h0002_0002_0002_0002_0002);
            chk("s2_rsp1_data", rsp1_data_w[k], 80'h0192_0192_0192_0192_0192);
        end

        // Requester 1 streams addresses 0..7 back-to-back.
        clear_counts();
        for (int i = 0; i < 8; i++) sa1[i] = 15'(i);
        sn0 = 0;
        sn1 = 8;
        stream();
        chk("s3_ticks", 80'(s_ticks), 80'd8);
        drain();
        for (int k = 0; k < 2; k++) begin
            chk("s3_rsp1_count", 80'(rcnt[k][1]), 80'd8);
            chk("s3_rsp1_data", rsp1_data_w[k], 80'h0007_0007_0007_0007_0007);
        end

        // Reset one cycle after an accept of address 5 kills that read.
        clear_counts();
        req0_valid = 1'b1;
        req0_addr  = 15'd5;
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < 2; k++) chk("s4_busy_before", 80'(busy_w[k]), 80'd1);
        reset = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) chk("s4_busy_after", 80'(busy_w[k]), 80'd0);
        tick();
        reset = 1'b0;
        drain();
        for (int k = 0; k < 2; k++) begin
            chk("s4_no_rsp0", 80'(rcnt[k][0]), 80'd0);
            chk("s4_no_rsp1", 80'(rcnt[k][1]), 80'd0);
        end
        sa0[0] = 15'd9;
        sa1[0] = 15'h20;
        sn0 = 1;
        sn1 = 1;
        stream();
        drain();
        if (gid_log.size() > 0) chk("s4_first_grant", 80'(gid_log[0]), 80'd0);
        else                    chk("s4_no_grant", 80'd0, 80'd1);
        for (int k = 0; k < 2; k++) begin
            chk("s4_rsp0_data", rsp0_data_w[k], 80'h0009_0009_0009_0009_0009);
            chk("s4_rsp1_data", rsp1_data_w[k], 80'h0020_0020_0020_0020_0020);
        end

        // Top address and its neighbour.
        sa0[0] = 15'h7FFE;
        sa1[0] = 15'h7FFF;
        stream();
        drain();
        for (int k = 0; k < 2; k++) begin
            chk("s5_rsp1_data", rsp1_data_w[k], 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
            chk("s5_rsp0_data", rsp0_data_w[k], 80'h7FFE_7FFE_7FFE_7FFE_7FFE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
